// File: rtl/iob_fifo_pkg.sv
// Shared helpers for the asymmetric FIFO family: integer min/max and ceil(log2).
package iob_fifo_pkg;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int clog2_i(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iob_2p_asym_ram.sv
// Two-port RAM with one write port and one registered read port whose widths differ by a power of 2.
module iob_2p_asym_ram
  import iob_fifo_pkg::*;
#(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 8,
  parameter int W_ADDR_W = 6,
  parameter int R_ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_we,
  input  logic [W_ADDR_W-1:0] i_waddr,
  input  logic [W_DATA_W-1:0] i_wdata,
  input  logic                i_re,
  input  logic [R_ADDR_W-1:0] i_raddr,
  output logic [R_DATA_W-1:0] o_rdata
);

  localparam int MIN_W = min_i(W_DATA_W, R_DATA_W);
  localparam int MAXU  = max_i(W_DATA_W, R_DATA_W) / MIN_W;
  localparam int LR    = clog2_i(MAXU);
  localparam int NWA   = ADDR_W - LR;
  localparam int NW    = 1 << NWA;

  // Each storage word is MAXU narrow units; unit 0 sits in the low bits.
  logic [MAXU-1:0][MIN_W-1:0] mem [NW];
  logic [R_DATA_W-1:0]        r_rdata;

  assign o_rdata = r_rdata;

  generate
    if (W_DATA_W == R_DATA_W) begin : g_eq
      always_ff @(posedge clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_rdata <= '0;
        else if (i_re) r_rdata <= mem[i_raddr];
      end
    end else if (W_DATA_W > R_DATA_W) begin : g_wide_wr
      logic [NWA-1:0] w_ridx;
      logic [LR-1:0]  w_rsub;

      assign w_ridx = i_raddr[R_ADDR_W-1:LR];
      assign w_rsub = i_raddr[LR-1:0];

      always_ff @(posedge clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_rdata <= '0;
        else if (i_re) r_rdata <= mem[w_ridx][w_rsub];
      end
    end else begin : g_wide_rd
      logic [NWA-1:0] w_widx;
      logic [LR-1:0]  w_wsub;

      assign w_widx = i_waddr[W_ADDR_W-1:LR];
      assign w_wsub = i_waddr[LR-1:0];

      always_ff @(posedge clk) begin
        if (i_we) mem[w_widx][w_wsub] <= i_wdata;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_rdata <= '0;
        else if (i_re) r_rdata <= mem[i_raddr];
      end
    end
  endgenerate

endmodule

// File: rtl/iob_sync_asym_fifo_v2.sv
// Single-clock FIFO with unequal write/read widths, threshold flags, sticky error status and flush.
module iob_sync_asym_fifo_v2
  import iob_fifo_pkg::*;
#(
  parameter int W_DATA_W   = 32,
  parameter int R_DATA_W   = 8,
  parameter int ADDR_W     = 8,
  parameter int AFULL_LVL  = 192,
  parameter int AEMPTY_LVL = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                full,
  output logic                almost_full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_valid,
  output logic                empty,
  output logic                almost_empty,
  output logic [ADDR_W:0]     level,
  output logic                overflow,
  output logic                underflow
);

  localparam int MIN_W    = min_i(W_DATA_W, R_DATA_W);
  localparam int WU       = W_DATA_W / MIN_W;
  localparam int RU       = R_DATA_W / MIN_W;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int W_ADDR_W = ADDR_W - clog2_i(WU);
  localparam int R_ADDR_W = ADDR_W - clog2_i(RU);

  localparam logic [ADDR_W:0] L_WU = WU[ADDR_W:0];
  localparam logic [ADDR_W:0] L_RU = RU[ADDR_W:0];

  logic [ADDR_W:0]     r_level;
  logic [W_ADDR_W-1:0] r_wptr;
  logic [R_ADDR_W-1:0] r_rptr;
  logic                r_rvalid;
  logic                r_ovf;
  logic                r_unf;

  logic                w_full;
  logic                w_empty;
  logic                w_wok;
  logic                w_rok;
  logic [R_DATA_W-1:0] w_rdata;

  // Flags are decoded from the unit count so both port widths share one occupancy view.
  assign w_full  = int'(r_level) > (DEPTH - WU);
  assign w_empty = int'(r_level) < RU;

  // A pending flush swallows same-cycle requests without flagging them.
  assign w_wok = w_en & ~w_full & ~clr;
  assign w_rok = r_en & ~w_empty & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_rvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (clr) begin
      r_level  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_rvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_level  <= r_level + (w_wok ? L_WU : '0) - (w_rok ? L_RU : '0);
      r_rvalid <= w_rok;
      if (w_wok) r_wptr <= r_wptr + 1'b1;
      if (w_rok) r_rptr <= r_rptr + 1'b1;
      if (w_en && w_full)  r_ovf <= 1'b1;
      if (r_en && w_empty) r_unf <= 1'b1;
    end
  end

  iob_2p_asym_ram #(
    .W_DATA_W (W_DATA_W),
    .R_DATA_W (R_DATA_W),
    .ADDR_W   (ADDR_W),
    .W_ADDR_W (W_ADDR_W),
    .R_ADDR_W (R_ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wok),
    .i_waddr (r_wptr),
    .i_wdata (w_data),
    .i_re    (w_rok),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = int'(r_level) >= AFULL_LVL;
  assign almost_empty = int'(r_level) <= AEMPTY_LVL;
  assign level        = r_level;
  assign r_data       = w_rdata;
  assign r_valid      = r_rvalid;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_iob_sync_asym_fifo_v2.sv
// Randomised bench: a byte-queue model of the 32->8 FIFO plus a directed 8->32 instance.
module tb_iob_sync_asym_fifo_v2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0, w_en = 1'b0, r_en = 1'b0;
  logic [31:0] w_data = '0;
  logic        full, almost_full, empty, almost_empty, r_valid, overflow, underflow;
  logic [7:0]  r_data;
  logic [8:0]  level;

  logic        clr2 = 1'b0, w_en2 = 1'b0, r_en2 = 1'b0;
  logic [7:0]  w_data2 = '0;
  logic        full2, almost_full2, empty2, almost_empty2, r_valid2, overflow2, underflow2;
  logic [31:0] r_data2;
  logic [4:0]  level2;

  always #5 clk = ~clk;

  iob_sync_asym_fifo_v2 #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(8),
                          .AFULL_LVL(192), .AEMPTY_LVL(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .w_data(w_data),
    .full(full), .almost_full(almost_full), .r_en(r_en), .r_data(r_data),
    .r_valid(r_valid), .empty(empty), .almost_empty(almost_empty),
    .level(level), .overflow(overflow), .underflow(underflow));

  iob_sync_asym_fifo_v2 #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4),
                          .AFULL_LVL(12), .AEMPTY_LVL(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr2), .w_en(w_en2), .w_data(w_data2),
    .full(full2), .almost_full(almost_full2), .r_en(r_en2), .r_data(r_data2),
    .r_valid(r_valid2), .empty(empty2), .almost_empty(almost_empty2),
    .level(level2), .overflow(overflow2), .underflow(underflow2));

  int checks = 0;
  int errors = 0;

  // Model: FIFO contents as a queue of bytes, 256 bytes of capacity.
  logic [7:0] q[$];
  logic [7:0] m_rdata = '0;
  bit         m_rv = 0, m_ovf = 0, m_unf = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, "_level"}, 64'(level), 64'(n));
    chk({tag, "_full"}, 64'(full), 64'(n + 4 > 256));
    chk({tag, "_empty"}, 64'(empty), 64'(n == 0));
    chk({tag, "_afull"}, 64'(almost_full), 64'(n >= 192));
    chk({tag, "_aempty"}, 64'(almost_empty), 64'(n <= 16));
    chk({tag, "_rvalid"}, 64'(r_valid), 64'(m_rv));
    chk({tag, "_rdata"}, 64'(r_data), 64'(m_rdata));
    chk({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, "_unf"}, 64'(underflow), 64'(m_unf));
  endtask

  task automatic step(input bit we, input bit re, input bit cl, input logic [31:0] wd,
                      input string tag);
    bit wok, rok;
    w_en = we; r_en = re; clr = cl; w_data = wd;
    @(posedge clk);
    if (cl) begin
      q.delete(); m_rv = 0; m_ovf = 0; m_unf = 0;
    end else begin
      wok = we && (q.size() + 4 <= 256);
      rok = re && (q.size() >= 1);
      if (we && !wok) m_ovf = 1;
      if (re && !rok) m_unf = 1;
      m_rv = rok;
      if (rok) m_rdata = q.pop_front();
      if (wok) for (int i = 0; i < 4; i++) q.push_back(wd[8*i +: 8]);
    end
    #1;
    w_en = 0; r_en = 0; clr = 0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    w_en = 0; r_en = 0; clr = 0;
    #2 rst_n = 1'b0;
    #2;
    q.delete(); m_rdata = '0; m_rv = 0; m_ovf = 0; m_unf = 0;
    check_all(tag);
    chk({tag, "_level2"}, 64'(level2), 64'd0);
    chk({tag, "_empty2"}, 64'(empty2), 64'd1);
    rst_n = 1'b1;
  endtask

  task automatic test_narrow_to_wide();
    logic [7:0] v [4];
    v[0] = 8'hAA; v[1] = 8'hBB; v[2] = 8'hCC; v[3] = 8'hDD;
    for (int i = 0; i < 3; i++) begin
      w_en2 = 1'b1; w_data2 = v[i];
      @(posedge clk); #1;
    end
    w_en2 = 1'b0;
    chk("t3_empty_3", 64'(empty2), 64'd1);
    chk("t3_level_3", 64'(level2), 64'd3);
    w_en2 = 1'b1; w_data2 = v[3];
    @(posedge clk); #1;
    w_en2 = 1'b0;
    chk("t3_empty_4", 64'(empty2), 64'd0);
    chk("t3_level_4", 64'(level2), 64'd4);
    r_en2 = 1'b1;
    @(posedge clk); #1;
    r_en2 = 1'b0;
    chk("t3_rvalid", 64'(r_valid2), 64'd1);
    chk("t3_rdata", 64'(r_data2), 64'hDDCCBBAA);
    chk("t3_level_0", 64'(level2), 64'd0);
    @(posedge clk); #1;
    chk("t3_rvalid_off", 64'(r_valid2), 64'd0);
    chk("t3_rdata_hold", 64'(r_data2), 64'hDDCCBBAA);
  endtask

  initial begin
    logic [7:0] t1e [4];
    bit we, re;
    int wp, rp;
    t1e[0] = 8'h11; t1e[1] = 8'h22; t1e[2] = 8'h33; t1e[3] = 8'h44;

    do_reset("reset");
    chk("reset_full2", 64'(full2), 64'd0);

    // 1: one wide word out as four little-endian bytes
    step(1, 0, 0, 32'h44332211, "t1w");
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, '0, "t1r");
      chk("t1_data", 64'(r_data), 64'(t1e[i]));
      chk("t1_valid", 64'(r_valid), 64'd1);
    end
    chk("t1_empty", 64'(empty), 64'd1);

    // 2: fill, overflow, drain
    for (int i = 0; i < 64; i++) step(1, 0, 0, $urandom, "t2fill");
    chk("t2_level", 64'(level), 64'd256);
    chk("t2_full", 64'(full), 64'd1);
    step(1, 0, 0, 32'hDEADBEEF, "t2ovf");
    chk("t2_ovf", 64'(overflow), 64'd1);
    chk("t2_level_hold", 64'(level), 64'd256);
    for (int i = 0; i < 256; i++) step(0, 1, 0, '0, "t2drain");
    step(0, 0, 1, '0, "t2clr");

    // 3: narrow-write / wide-read instance
    test_narrow_to_wide();

    // 4: simultaneous write and read, then underflow
    step(1, 0, 0, $urandom, "t4w");
    step(1, 0, 0, $urandom, "t4w");
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, $urandom, "t4rw");
      chk("t4_step", 64'(level), 64'(8 + 3 * (i + 1)));
    end
    while (q.size() > 0) step(0, 1, 0, '0, "t4drain");
    step(0, 1, 0, '0, "t4unf");
    chk("t4_unf", 64'(underflow), 64'd1);
    chk("t4_no_rvalid", 64'(r_valid), 64'd0);
    step(0, 0, 1, '0, "t4clr");

    // 5: random stream with drifting bias to visit full and empty repeatedly
    for (int i = 0; i < 1000; i++) begin
      wp = ((i / 125) % 2 == 0) ? 70 : 20;
      rp = ((i / 125) % 2 == 0) ? 60 : 85;
      we = $urandom_range(0, 99) < wp;
      re = $urandom_range(0, 99) < rp;
      step(we, re, 0, $urandom, "t5");
    end

    // 6: reset mid-stream, then flush with colliding requests
    for (int i = 0; i < 6; i++) step(1, i[0], 0, $urandom, "t6pre");
    step(0, 1, 0, '0, "t6inflight");
    do_reset("t6rst");
    step(1, 0, 0, 32'hA1B2C3D4, "t6w");
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0, "t6r");
    chk("t6_last", 64'(r_data), 64'hA1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, $urandom, "t6fill");
    step(1, 1, 1, 32'h55555555, "t6clr");
    chk("t6_clr_level", 64'(level), 64'd0);
    chk("t6_clr_rvalid", 64'(r_valid), 64'd0);
    step(1, 0, 0, 32'h0C0B0A09, "t6w2");
    step(0, 1, 0, '0, "t6r2");
    chk("t6_new_data", 64'(r_data), 64'h09);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
